obj_render_sched: RTL and testbench

Owns the command port of the object unit and shares it between the matrix unit and a per-frame render walk.
On frame_start it snapshots the object map and visits every live object in ascending index order. For each object it issues a ref_addr lookup, waits for addr_vld, then hands the object to the rasterizer and waits for obj_done.
Matrix commands always have priority on the port. The walk only uses the port in cycles the matrix unit leaves free.

---
 rtl/obj_render_sched.sv | 99 +++++++++
 tb/tb_obj_render_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/obj_render_sched.sv
// obj_render_sched: shares the object-unit command port between matrix commands and a per-frame render walk.
module obj_render_sched #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [31:0] obj_map,
    input  logic        m_crt_obj,
    input  logic        m_del_obj,
    input  logic        m_del_all,
    input  logic        m_ref_addr,
    input  logic [4:0]  m_obj_num,
    output logic        m_ready,
    output logic        m_addr_vld,
    output logic        crt_obj,
    output logic        del_obj,
    output logic        del_all,
    output logic        ref_addr,
    output logic [4:0]  obj_num,
    input  logic        addr_vld,
    output logic        obj_start,
    output logic [4:0]  obj_idx,
    input  logic        obj_done,
    output logic        frame_done,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_cmd
);
    localparam logic [1:0] P_IDLE = 2'd0, P_MTX = 2'd1, P_SCH = 2'd2;
    localparam logic [2:0] S_IDLE = 3'd0, S_SCAN = 3'd1, S_REQ = 3'd2,
                           S_WAIT = 3'd3, S_RENDER = 3'd4, S_DONE = 3'd5;
    logic [1:0]  port;
    logic [2:0]  st;
    logic [31:0] pend, pend_base, pend_nxt, lsb;
    logic [4:0]  cur, lsb_idx;
    logic [3:0]  timer;
    logic        m_any, m_ref, w_iss, tmo, got_addr;
    assign m_ready    = port == P_IDLE;
    assign m_any      = m_crt_obj | m_del_obj | m_del_all | m_ref_addr;
    assign del_all    = m_ready & m_del_all;
    assign del_obj    = m_ready & m_del_obj & ~m_del_all;
    assign crt_obj    = m_ready & m_crt_obj & ~m_del_all & ~m_del_obj;
    assign m_ref      = m_ready & m_ref_addr & ~m_del_all & ~m_del_obj & ~m_crt_obj;
    // The walk only takes the port in a cycle the matrix leaves completely free.
    assign w_iss      = st == S_REQ && m_ready && !m_any;
    assign ref_addr   = m_ref | w_iss;
    assign obj_num    = (m_ready && m_any) ? m_obj_num : cur;
    assign m_addr_vld = port == P_MTX && addr_vld;
    assign busy       = st != S_IDLE;
    assign frame_done = st == S_DONE;
    assign got_addr   = st == S_WAIT && addr_vld;
    assign tmo        = st == S_WAIT && !addr_vld && timer == 4'(TIMEOUT);
    assign lsb        = pend & (~pend + 32'd1);
    assign pend_base  = (st == S_IDLE && frame_start) ? obj_map : (st == S_SCAN ? pend & ~lsb : pend);
    assign pend_nxt   = del_all ? '0 : pend_base & ~(del_obj ? 32'd1 << m_obj_num : 32'd0);
    always_comb begin
        lsb_idx = '0;
        for (int i = 31; i >= 0; i--) if (pend[i]) lsb_idx = 5'(i);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port        <= P_IDLE;
            st          <= S_IDLE;
            pend        <= '0;
            cur         <= '0;
            timer       <= '0;
            obj_start   <= 1'b0;
            obj_idx     <= '0;
            err_timeout <= 1'b0;
            err_cmd     <= 1'b0;
        end else begin
            port        <= (port == P_IDLE) ? ((crt_obj | m_ref) ? P_MTX : w_iss ? P_SCH : P_IDLE)
                         : (addr_vld || tmo) ? P_IDLE : port;
            pend        <= pend_nxt;
            obj_start   <= got_addr;
            obj_idx     <= got_addr ? cur : obj_idx;
            err_timeout <= err_timeout | tmo;
            err_cmd     <= err_cmd | (m_any & ~m_ready) | (frame_start & busy);
            case (st)
                S_IDLE:   st <= frame_start ? S_SCAN : S_IDLE;
                S_SCAN: begin
                    st  <= (pend == '0) ? S_DONE : S_REQ;
                    cur <= (pend == '0) ? cur : lsb_idx;
                end
                S_REQ: begin
                    st    <= w_iss ? S_WAIT : S_REQ;
                    timer <= '0;
                end
                S_WAIT: begin
                    st    <= got_addr ? S_RENDER : tmo ? S_SCAN : S_WAIT;
                    timer <= timer + 4'd1;
                end
                S_RENDER: st <= obj_done ? S_SCAN : S_RENDER;
                default:  st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_obj_render_sched.sv
// tb_obj_render_sched: directed self-checking bench for obj_render_sched.
module tb_obj_render_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start, m_crt_obj, m_del_obj, m_del_all, m_ref_addr, addr_vld, obj_done;
    logic [31:0] obj_map;
    logic [4:0]  m_obj_num, obj_num, obj_idx;
    logic        m_ready, m_addr_vld, crt_obj, del_obj, del_all, ref_addr;
    logic        obj_start, frame_done, busy, err_timeout, err_cmd;
    int          checks = 0, errors = 0;

    obj_render_sched #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .obj_map(obj_map),
        .m_crt_obj(m_crt_obj), .m_del_obj(m_del_obj), .m_del_all(m_del_all),
        .m_ref_addr(m_ref_addr), .m_obj_num(m_obj_num), .m_ready(m_ready),
        .m_addr_vld(m_addr_vld), .crt_obj(crt_obj), .del_obj(del_obj), .del_all(del_all),
        .ref_addr(ref_addr), .obj_num(obj_num), .addr_vld(addr_vld), .obj_start(obj_start),
        .obj_idx(obj_idx), .obj_done(obj_done), .frame_done(frame_done), .busy(busy),
        .err_timeout(err_timeout), .err_cmd(err_cmd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ref(input string tag, input logic [4:0] idx);
        int n = 0;
        while (!ref_addr && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_ref"}, 32'(ref_addr), 1);
        chk({tag, "_num"}, 32'(obj_num), 32'(idx));
    endtask

    // addr_vld one cycle after ref_addr, obj_done three cycles after obj_start
    task automatic serve(input string tag, input logic [4:0] idx);
        wait_ref(tag, idx);
        step();
        addr_vld = 1'b1;
        #1;
        chk({tag, "_mav"}, 32'(m_addr_vld), 0);
        step();
        addr_vld = 1'b0;
        chk({tag, "_start"}, 32'(obj_start), 1);
        chk({tag, "_idx"}, 32'(obj_idx), 32'(idx));
        step();
        chk({tag, "_start_pulse"}, 32'(obj_start), 0);
        chk({tag, "_idx_hold"}, 32'(obj_idx), 32'(idx));
        step();
        step();
        obj_done = 1'b1;
        step();
        obj_done = 1'b0;
    endtask

    task automatic wait_fd(input string tag);
        int n = 0;
        while (!frame_done && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_fd"}, 32'(frame_done), 1);
        step();
        chk({tag, "_fd_pulse"}, 32'(frame_done), 0);
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic start_frame(input logic [31:0] map);
        obj_map = map;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        {frame_start, m_crt_obj, m_del_obj, m_del_all, m_ref_addr, addr_vld, obj_done} = '0;
        obj_map = '0;
        m_obj_num = '0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(m_ready), 1);
        chk("rst_start", 32'(obj_start), 0);
        chk("rst_errs", {30'd0, err_timeout, err_cmd}, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // two-object frame
        start_frame(32'h0000_0005);
        serve("t1a", 5'd0);
        serve("t1b", 5'd2);
        wait_fd("t1");
        chk("t1_tmo", 32'(err_timeout), 0);

        // matrix create wins the port while the walk waits in S_REQ
        start_frame(32'h0000_0008);
        step();
        m_crt_obj = 1'b1;
        m_obj_num = 5'd7;
        #1;
        chk("t2_crt", 32'(crt_obj), 1);
        chk("t2_num", 32'(obj_num), 7);
        chk("t2_noref", 32'(ref_addr), 0);
        step();
        m_crt_obj = 1'b0;
        chk("t2_busyport", 32'(m_ready), 0);
        chk("t2_hold", 32'(ref_addr), 0);
        step();
        step();
        step();
        addr_vld = 1'b1;
        #1;
        chk("t2_mav", 32'(m_addr_vld), 1);
        chk("t2_hold2", 32'(ref_addr), 0);
        step();
        addr_vld = 1'b0;
        chk("t2_ready", 32'(m_ready), 1);
        serve("t2", 5'd3);
        wait_fd("t2");
        chk("t2_errcmd", 32'(err_cmd), 0);

        // delete a pending object mid-frame; index 31 still fetched
        start_frame(32'h8000_0003);
        wait_ref("t3a", 5'd0);
        step();
        addr_vld = 1'b1;
        step();
        addr_vld = 1'b0;
        chk("t3_start", 32'(obj_start), 1);
        m_del_obj = 1'b1;
        m_obj_num = 5'd1;
        #1;
        chk("t3_del", 32'(del_obj), 1);
        chk("t3_delnum", 32'(obj_num), 1);
        step();
        m_del_obj = 1'b0;
        step();
        obj_done = 1'b1;
        step();
        obj_done = 1'b0;
        serve("t3b", 5'd31);
        wait_fd("t3");

        // lookup timeout on obj 1, then obj 4
        start_frame(32'h0000_0012);
        wait_ref("t4a", 5'd1);
        for (int i = 0; i < 16; i++) step();
        chk("t4_tmo_early", 32'(err_timeout), 0);
        chk("t4_port_held", 32'(m_ready), 0);
        step();
        chk("t4_tmo", 32'(err_timeout), 1);
        chk("t4_ready", 32'(m_ready), 1);
        serve("t4b", 5'd4);
        wait_fd("t4");
        chk("t4_sticky", 32'(err_timeout), 1);

        // del_all with simultaneous commands: only del_all forwarded, pending objects dropped
        start_frame(32'h0000_0301);
        wait_ref("t7", 5'd0);
        step();
        addr_vld = 1'b1;
        step();
        addr_vld = 1'b0;
        {m_del_all, m_del_obj, m_crt_obj} = 3'b111;
        m_obj_num = 5'd8;
        #1;
        chk("t7_pri", {29'd0, del_all, del_obj, crt_obj}, 32'b100);
        step();
        {m_del_all, m_del_obj, m_crt_obj} = 3'b000;
        chk("t7_ready", 32'(m_ready), 1);
        obj_done = 1'b1;
        step();
        obj_done = 1'b0;
        chk("t7_noref", 32'(ref_addr), 0);
        step();
        chk("t7_fd", 32'(frame_done), 1);
        step();
        chk("t7_errcmd", 32'(err_cmd), 0);

        // matrix command while the walk owns the port, frame_start while busy
        start_frame(32'h0000_0020);
        wait_ref("t5", 5'd5);
        step();
        m_ref_addr = 1'b1;
        m_obj_num = 5'd9;
        #1;
        chk("t5_noref", 32'(ref_addr), 0);
        chk("t5_num", 32'(obj_num), 5);
        step();
        m_ref_addr = 1'b0;
        chk("t5_errcmd", 32'(err_cmd), 1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("t5_busy", 32'(busy), 1);
        chk("t5_errcmd2", 32'(err_cmd), 1);
        addr_vld = 1'b1;
        step();
        addr_vld = 1'b0;
        chk("t5_start", 32'(obj_start), 1);
        chk("t5_idx", 32'(obj_idx), 5);

        // asynchronous reset in S_RENDER
        rst_n = 1'b0;
        #1;
        chk("t6_start", 32'(obj_start), 0);
        chk("t6_idx", 32'(obj_idx), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_errs", {30'd0, err_timeout, err_cmd}, 0);
        chk("t6_fd", 32'(frame_done), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_idle", 32'(busy), 0);
        chk("t6_ready", 32'(m_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
